// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the sequence detector.
// A one-word holding buffer lets consecutive words stream out with no gap bits.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             enable,
    output logic             x_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             holdFull_q, holdFull_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             x_q, x_d;
    logic             bitValid_q, bitValid_d;
    logic             frameStart_q, frameStart_d;

    logic             accept;
    logic             headBit;
    logic [WIDTH-1:0] shifted;

    assign data_ready  = !reset && !holdFull_q;
    assign accept      = data_valid && data_ready;
    assign busy        = (state_q == SHIFT) || holdFull_q;
    assign x_out       = x_q;
    assign bit_valid   = bitValid_q;
    assign frame_start = frameStart_q;

    // The head is always the bit about to leave; shifting moves the next one into its place.
    assign headBit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shifted = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        holdFull_d   = holdFull_q;
        shift_d      = shift_q;
        count_d      = count_q;
        x_d          = x_q;
        bitValid_d   = 1'b0;
        frameStart_d = 1'b0;

        // accept only happens with an empty buffer, so it never races the reloads below
        if (accept) begin
            hold_d     = data_in;
            holdFull_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                x_d = IDLE_BIT;
                if (holdFull_q) begin
                    shift_d    = hold_q;
                    holdFull_d = 1'b0;
                    count_d    = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    x_d          = headBit;
                    bitValid_d   = 1'b1;
                    frameStart_d = (count_q == '0);
                    shift_d      = shifted;
                    count_d      = count_q + CW'(1);
                    if (count_q == LAST) begin
                        count_d = '0;
                        if (holdFull_q) begin
                            shift_d    = hold_q;
                            holdFull_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            holdFull_q   <= 1'b0;
            shift_q      <= '0;
            count_q      <= '0;
            x_q          <= IDLE_BIT;
            bitValid_q   <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            holdFull_q   <= holdFull_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            x_q          <= x_d;
            bitValid_q   <= bitValid_d;
            frameStart_q <= frameStart_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: an MSB-first and an LSB-first instance share stimulus
// and are compared every cycle against a word-level reference model.
module tb_serial_bit_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] dataIn;
    logic         dataValid;
    logic         enable;

    logic dataReady0, xOut0, bitValid0, frameStart0, busy0;
    logic dataReady1, xOut1, bitValid1, frameStart1, busy1;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state: buffered word, word in flight and how many of its bits are out
    logic         mHoldFull;
    logic [W-1:0] mHold;
    logic         mActive;
    logic [W-1:0] mCur;
    int           mPos;
    logic         mX0, mX1, mBv, mFs;
    logic         lastAccept;
    int           acceptCycle;

    logic cap0[$];
    logic cap1[$];
    int   capCycle[$];
    int   fsIdx[$];

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutMsb (
        .clk(clk), .reset(reset), .data_in(dataIn), .data_valid(dataValid),
        .data_ready(dataReady0), .enable(enable), .x_out(xOut0),
        .bit_valid(bitValid0), .frame_start(frameStart0), .busy(busy0)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dutLsb (
        .clk(clk), .reset(reset), .data_in(dataIn), .data_valid(dataValid),
        .data_ready(dataReady1), .enable(enable), .x_out(xOut1),
        .bit_valid(bitValid1), .frame_start(frameStart1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level behaviour at one rising edge, using the inputs presented before it
    task automatic modelEdge();
        logic acc;
        acc        = dataValid && !reset && !mHoldFull;
        lastAccept = acc;
        if (reset) begin
            mHoldFull = 1'b0;
            mActive   = 1'b0;
            mPos      = 0;
            mX0       = 1'b0;
            mX1       = 1'b0;
            mBv       = 1'b0;
            mFs       = 1'b0;
        end else begin
            if (!mActive) begin
                mX0 = 1'b0;
                mX1 = 1'b0;
                mBv = 1'b0;
                mFs = 1'b0;
                if (mHoldFull) begin
                    mCur      = mHold;
                    mPos      = 0;
                    mHoldFull = 1'b0;
                    mActive   = 1'b1;
                end
            end else if (enable) begin
                mX0 = mCur[W-1-mPos];
                mX1 = mCur[mPos];
                mBv = 1'b1;
                mFs = (mPos == 0);
                mPos++;
                if (mPos == W) begin
                    mPos = 0;
                    if (mHoldFull) begin
                        mCur      = mHold;
                        mHoldFull = 1'b0;
                    end else begin
                        mActive = 1'b0;
                    end
                end
            end else begin
                mBv = 1'b0;
                mFs = 1'b0;
            end
            if (acc) begin
                mHold     = dataIn;
                mHoldFull = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        cycle++;
        if (lastAccept) acceptCycle = cycle;
        checkOutput("x_out_msb",       xOut0,       mX0);
        checkOutput("x_out_lsb",       xOut1,       mX1);
        checkOutput("bit_valid_msb",   bitValid0,   mBv);
        checkOutput("bit_valid_lsb",   bitValid1,   mBv);
        checkOutput("frame_start_msb", frameStart0, mFs);
        checkOutput("frame_start_lsb", frameStart1, mFs);
        checkOutput("busy_msb",        busy0,       mActive || mHoldFull);
        checkOutput("busy_lsb",        busy1,       mActive || mHoldFull);
        checkOutput("data_ready_msb",  dataReady0,  !reset && !mHoldFull);
        checkOutput("data_ready_lsb",  dataReady1,  !reset && !mHoldFull);
        if (bitValid0) begin
            if (frameStart0) fsIdx.push_back(cap0.size());
            cap0.push_back(xOut0);
            capCycle.push_back(cycle);
        end
        if (bitValid1) cap1.push_back(xOut1);
    endtask

    task automatic clearCap();
        cap0.delete();
        cap1.delete();
        capCycle.delete();
        fsIdx.delete();
    endtask

    function automatic logic [31:0] packed0();
        logic [31:0] v = '0;
        foreach (cap0[i]) v = {v[30:0], cap0[i]};
        return v;
    endfunction

    function automatic logic [31:0] packed1();
        logic [31:0] v = '0;
        foreach (cap1[i]) v = {v[30:0], cap1[i]};
        return v;
    endfunction

    task automatic sendWord(input logic [W-1:0] w);
        int n = 0;
        dataIn    = w;
        dataValid = 1'b1;
        do begin
            applyStimulus();
            n++;
        end while (!lastAccept && n < 200);
        if (!lastAccept) checkOutput("send_timeout", 32'd1, 32'd0);
        dataValid = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int n = 0;
        while ((mActive || mHoldFull) && n < 200) begin
            if (toggle) enable = ~enable;
            applyStimulus();
            n++;
        end
        if (mActive || mHoldFull) checkOutput("drain_timeout", 32'd1, 32'd0);
        enable = 1'b1;
        applyStimulus();
    endtask

    initial begin
        int n;
        mHoldFull = 1'b0; mHold = '0; mActive = 1'b0; mCur = '0; mPos = 0;
        mX0 = 1'b0; mX1 = 1'b0; mBv = 1'b0; mFs = 1'b0; lastAccept = 1'b0; acceptCycle = 0;
        reset = 1'b1; dataIn = '0; dataValid = 1'b0; enable = 1'b1;

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("reset_data_ready", dataReady0, 1'b0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("post_reset_ready", dataReady0, 1'b1);

        // Single word, MSB-first and LSB-first, latency and framing
        clearCap();
        sendWord(8'hB4);
        checkOutput("ready_after_accept", dataReady0, 1'b0);
        drain(1'b0);
        checkOutput("b4_count",       cap0.size(), 8);
        checkOutput("b4_msb_bits",    packed0(), 32'hB4);
        checkOutput("b4_lsb_bits",    packed1(), 32'h2D);
        checkOutput("b4_latency",     capCycle[0] - acceptCycle, 2);
        checkOutput("b4_frame_count", fsIdx.size(), 1);
        checkOutput("b4_frame_pos",   fsIdx[0], 0);
        checkOutput("b4_idle_x",      xOut0, 1'b0);
        checkOutput("b4_idle_busy",   busy0, 1'b0);

        // Back-to-back words stream without a gap
        clearCap();
        sendWord(8'h0F);
        sendWord(8'hF0);
        drain(1'b0);
        checkOutput("b2b_count",  cap0.size(), 16);
        checkOutput("b2b_bits",   packed0(), 32'h0FF0);
        checkOutput("b2b_nogap",  capCycle[15] - capCycle[0], 15);
        checkOutput("b2b_frames", fsIdx.size(), 2);
        checkOutput("b2b_frame1", fsIdx[1], 8);

        // Alternating enable
        clearCap();
        sendWord(8'hB4);
        drain(1'b1);
        checkOutput("toggle_bits", packed0(), 32'hB4);
        checkOutput("toggle_span", capCycle[7] - capCycle[0], 14);

        // Reset mid-word with a buffered word
        clearCap();
        sendWord(8'hAA);
        sendWord(8'h55);
        n = 0;
        while (cap0.size() < 3 && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("mid_bits_before_reset", cap0.size(), 3);
        reset = 1'b1;
        applyStimulus();
        checkOutput("reset_x",    xOut0, 1'b0);
        checkOutput("reset_bv",   bitValid0, 1'b0);
        checkOutput("reset_busy", busy0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("reset_drop_ready", dataReady0, 1'b1);
        clearCap();
        for (int i = 0; i < 20; i++) applyStimulus();
        checkOutput("no_bits_after_reset", cap0.size(), 0);

        // Word offered while the buffer is full is not taken
        clearCap();
        sendWord(8'h3C);
        sendWord(8'h11);
        enable    = 1'b0;
        dataIn    = 8'hEE;
        dataValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("full_not_ready", dataReady0, 1'b0);
        end
        enable = 1'b1;
        sendWord(8'h99);
        drain(1'b0);
        checkOutput("full_msb_bits", packed0(), 32'h3C1199);
        checkOutput("full_lsb_bits", packed1(), 32'h3C8899);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            dataValid = $urandom_range(0, 1) == 1;
            dataIn    = W'($urandom);
            enable    = $urandom_range(0, 3) != 0;
            applyStimulus();
        end
        reset = 1'b0; dataValid = 1'b0;
        drain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial front end that sits directly upstream of the sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on `x_out`, which drives the detector's serial input `x`.
- A one-word holding buffer lets consecutive words stream with no gap bits, so patterns that span word boundaries reach the detector intact.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on `x_out` when no word is being sent.

Ports:
- clk  input  1  rising-edge clock shared with the detector.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to serialise.
- data_valid  input  1  `data_in` is valid.
- data_ready  output  1  holding buffer can accept a word.
- enable  input  1  bit strobe; one bit is emitted per clock with `enable`=1.
- x_out  output  1  serial bit to the detector's `x`; registered.
- bit_valid  output  1  `x_out` carries a new bit this cycle; registered.
- frame_start  output  1  `x_out` is the first bit of a word; registered.
- busy  output  1  a word is being shifted or is waiting in the holding buffer.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All state updates on the `clk` rising edge.
- Reset values:
  - `x_out`=IDLE_BIT; `bit_valid`=0; `frame_start`=0; `busy`=0.
  - Holding buffer empty, shift register 0, bit counter 0, state IDLE.
  - `data_ready`=0 while `reset`=1.
- Reset mid-word discards both the partial word and the buffered word; no further bits of either are emitted.
- Handshake:
  - `data_ready` = !reset & !hold_full. It has no combinational dependency on `enable` or `data_valid`.
  - A word transfers on an edge where `data_valid` & `data_ready`; `hold_full` is set.
  - While `hold_full`=1, `data_in` is ignored and the buffered word is never overwritten.
- States:
  - IDLE:
    - Each edge: `x_out`<=IDLE_BIT, `bit_valid`<=0, `frame_start`<=0.
    - If `hold_full`: shift register <= hold, `hold_full`<=0, counter<=0, go to SHIFT.
    - The load does not require `enable`.
  - SHIFT, edge with `enable`=1:
    - `x_out`<= current head bit (MSB if MSB_FIRST, else LSB).
    - `bit_valid`<=1; `frame_start`<=(counter==0).
    - Shift the register toward the head; counter++.
    - When counter==WIDTH-1 (last bit):
      - If `hold_full`: reload from hold, clear `hold_full`, counter<=0, stay in SHIFT. The next enabled edge emits bit 0 of the new word with no gap.
      - Else: go to IDLE.
  - SHIFT, edge with `enable`=0:
    - `bit_valid`<=0, `frame_start`<=0; `x_out` holds its previous value.
    - No shift, no counter change, no reload.
- Latency with `enable` held at 1:
  - Word accepted at edge N, loaded at edge N+1, first bit on `x_out` after edge N+2.
  - WIDTH enabled cycles per word.
- Back-to-back:
  - The buffer empties at the load edge and `data_ready` rises the next cycle.
  - Because WIDTH>=2, a source that keeps `data_valid`=1 always refills the buffer before the last bit, so the stream has no gap.
- `busy` = (state==SHIFT) | `hold_full`; combinational from registers.
- Bits are never duplicated or dropped. Exactly WIDTH `bit_valid` pulses per accepted word, and exactly one of them carries `frame_start`.

Test Plan:
1. Reset; `enable`=1; send 8'hB4 once → `data_ready` falls the cycle after acceptance. After N+2, `x_out`=1,0,1,1,0,1,0,0 with `bit_valid`=1 for 8 cycles and `frame_start` on the first bit only. Then `x_out`=0 and `busy`=0.
2. Hold `data_valid`=1 with 8'h0F then 8'hF0, `enable`=1 → 16 contiguous valid bits 00001111 11110000, with no `bit_valid` gap and `frame_start` at bits 0 and 8.
3. 8'hB4 with `enable` toggling 1,0,1,0… → same 8-bit sequence, emitted only on enabled cycles. `x_out` is stable on disabled cycles and `bit_valid`=0 there.
4. MSB_FIRST=0, word 8'hB4 → `x_out`=0,0,1,0,1,1,0,1.
5. Assert `reset` after the 3rd bit of 8'hAA while 8'h55 is buffered → the next cycle shows `x_out`=0, `bit_valid`=0, `busy`=0, and `data_ready`=1 after `reset` drops. No bits of 8'hAA or 8'h55 appear afterwards.
6. Present a new word with `data_valid`=1 while the buffer is full → no transfer. The buffered word is emitted unchanged and the new word is accepted only once `data_ready` rises.
